// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the multiply/divide sequencer and the control decoder:
// function codes, FSM state encoding, iteration count and a magnitude helper.
package muldiv_sequencer_pkg;

  // Function codes as presented on the func input
  localparam logic [3:0] FUNC_MULT = 4'b0100;
  localparam logic [3:0] FUNC_DIV  = 4'b1000;

  // Sequencer state encoding
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // One iteration per operand bit
  localparam int ITER_COUNT = 16;

  // Operation latched at acceptance
  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_e;

  // Two's-complement magnitude; -32768 maps to the unsigned value 32768
  function automatic logic [15:0] abs16(input logic [15:0] v);
    return v[15] ? (~v + 16'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// Single combinational iteration of the unsigned core: one shift-add step for
// MULT or one restoring-division step for DIV.
module muldiv_step
  import muldiv_sequencer_pkg::*;
(
  input  op_e         op,
  input  logic [3:0]  bit_idx,  // multiplier bit examined this iteration
  input  logic [15:0] mcand,    // |multiplicand|
  input  logic [15:0] divisor,  // |multiplier| for MULT, |divisor| for DIV
  input  logic [31:0] acc_in,   // MULT: running product; DIV: [15:0] dividend/quotient shifter
  input  logic [16:0] rem_in,   // DIV partial remainder
  output logic [31:0] acc_out,
  output logic [16:0] rem_out
);

  logic [16:0] shifted;
  logic [16:0] trial;
  logic        fits;

  // One iteration of the selected algorithm
  // NOTE: every output gets a default before any branch so no path can leave it unassigned and infer a latch.
  always_comb begin
    acc_out = acc_in;
    rem_out = rem_in;
    shifted = {rem_in[15:0], acc_in[15]};
    trial   = shifted - {1'b0, divisor};
    fits    = (shifted >= {1'b0, divisor});
    if (op == OP_MULT) begin
      if (divisor[bit_idx]) begin
        acc_out = acc_in + ({16'd0, mcand} << bit_idx);
      end
    end else begin
      // Quotient bits enter from the right as dividend bits leave from the left
      acc_out = {16'd0, acc_in[14:0], fits};
      rem_out = fits ? trial : shifted;
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative signed 16x16 multiplier / 16/16 divider. Operands are reduced to
// magnitudes at acceptance, iterated 16 times by muldiv_step, and sign-fixed
// in a single FIX cycle. Divide-by-zero short-circuits straight to DONE.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  func,
  input  logic [15:0] opA,
  input  logic [15:0] opB,
  input  logic        flush,
  output logic        stall,
  output logic        done,
  output logic [15:0] resHi,
  output logic [15:0] resLo,
  output logic        divZero
);

  logic [1:0]  state;
  logic [4:0]  count;
  op_e         op;
  logic [15:0] mag_a;
  logic [15:0] mag_b;
  logic        neg_res;
  logic        neg_a;
  logic [31:0] acc;
  logic [16:0] rem;
  logic [31:0] acc_nx;
  logic [16:0] rem_nx;

  logic        valid_func;
  logic        accept;
  logic        div_by_zero;
  logic [31:0] prod_fix;
  logic [15:0] quo_fix;
  logic [15:0] rem_fix;

  // A start is taken only from IDLE/DONE with a recognised func, and never alongside a flush
  assign valid_func  = (func == FUNC_MULT) || (func == FUNC_DIV);
  assign accept      = ((state == S_IDLE) || (state == S_DONE)) && start && valid_func && !flush;
  assign div_by_zero = (func == FUNC_DIV) && (opB == 16'd0);
  assign stall       = accept || (state == S_BUSY) || (state == S_FIX);
  assign done        = (state == S_DONE);

  muldiv_step u_step (
    .op      (op),
    .bit_idx (count[3:0]),
    .mcand   (mag_a),
    .divisor (mag_b),
    .acc_in  (acc),
    .rem_in  (rem),
    .acc_out (acc_nx),
    .rem_out (rem_nx)
  );

  // Sign fix-up of the unsigned core results
  always_comb begin
    prod_fix = neg_res ? (~acc + 32'd1) : acc;
    quo_fix  = neg_res ? (~acc[15:0] + 16'd1) : acc[15:0];
    rem_fix  = neg_a ? (~rem[15:0] + 16'd1) : rem[15:0];
  end

  // FSM, iteration counter and operand capture
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      count   <= 5'd0;
      op      <= OP_MULT;
      mag_a   <= 16'd0;
      mag_b   <= 16'd0;
      neg_res <= 1'b0;
      neg_a   <= 1'b0;
      acc     <= 32'd0;
      rem     <= 17'd0;
    end else if (accept) begin
      op      <= (func == FUNC_DIV) ? OP_DIV : OP_MULT;
      mag_a   <= abs16(opA);
      mag_b   <= abs16(opB);
      neg_res <= opA[15] ^ opB[15];
      neg_a   <= opA[15];
      count   <= 5'd0;
      acc     <= (func == FUNC_DIV) ? {16'd0, abs16(opA)} : 32'd0;
      rem     <= 17'd0;
      state   <= div_by_zero ? S_DONE : S_BUSY;
    end else begin
      case (state)
        S_BUSY: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            acc   <= acc_nx;
            rem   <= rem_nx;
            count <= count + 5'd1;
            if (count == 5'(ITER_COUNT - 1)) begin
              state <= S_FIX;
            end
          end
        end
        S_FIX:   state <= flush ? S_IDLE : S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Result registers: written at FIX or on a divide-by-zero acceptance, held otherwise
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resHi   <= 16'd0;
      resLo   <= 16'd0;
      divZero <= 1'b0;
    end else if (accept && div_by_zero) begin
      resHi   <= opA;
      resLo   <= 16'hFFFF;
      divZero <= 1'b1;
    end else if (accept) begin
      divZero <= 1'b0;
    end else if ((state == S_FIX) && !flush) begin
      if (op == OP_DIV) begin
        resHi <= rem_fix;
        resLo <= quo_fix;
      end else begin
        resHi <= prod_fix[31:16];
        resLo <= prod_fix[15:0];
      end
    end
  end

endmodule
